// File: rtl/uart_pkg.sv
// Shared definitions for the memory-to-UART transmitter: the frame state
// encoding and the line levels used for start, stop and idle.
// Optional build macro: UART_PARITY_EN adds an even-parity bit to each frame.
package uart_pkg;

   // Frame sequencer states; PARITY exists only in parity-enabled builds.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_state_t;

   // Line levels for the framing bits; the line idles at the stop level.
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT clocks.
// restart zeroes the count so the first bit of a frame is a full period long.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-CLKS_PER_BIT counter, wrapping from LAST to zero.
   always_ff @(posedge clk) begin
      if (reset || restart)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/mem_uart_tx.sv
// Serialises a stored BIT_WIDTH-bit word onto a UART line, least-significant
// byte first, each byte framed as start, 8 data bits (LSB first), optional
// parity and stop. Bytes of one word are sent back to back.
// Optional build macro: UART_PARITY_EN inserts an even-parity bit per byte.
//
// Handshake: send is taken only while busy=0, and the word on data is
// captured in that same edge; busy then stays high for the whole word, send
// and data are ignored, and done pulses for one cycle as busy falls.
module mem_uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 115_200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 send,
   input  logic [BIT_WIDTH-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int NBYTES       = BIT_WIDTH / 8;
   localparam int BW           = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

   uart_state_t          state, state_n;
   logic [BIT_WIDTH-1:0] shift_q;
   logic [2:0]           bit_idx;
   logic [BW-1:0]        byte_idx;
   logic                 par_q;
   logic                 done_q;
   logic                 tick;
   logic                 accept;

   assign accept = (state == IDLE) && send;

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .restart (accept),
      .tick    (tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state logic: every non-idle state advances on a bit-period tick.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (send) state_n = START;
         START: if (tick) state_n = DATA;
`ifdef UART_PARITY_EN
         DATA:   if (tick && bit_idx == 3'd7) state_n = PARITY;
         PARITY: if (tick) state_n = STOP;
`else
         DATA:  if (tick && bit_idx == 3'd7) state_n = STOP;
`endif
         STOP:  if (tick) state_n = (byte_idx == LAST_BYTE) ? IDLE : START;
         default: state_n = IDLE;
      endcase
   end

   // Line driver: the level on tx follows the current frame state.
   always_comb begin
      tx = STOP_BIT;
      case (state)
         START:  tx = START_BIT;
         DATA:   tx = shift_q[0];
`ifdef UART_PARITY_EN
         PARITY: tx = par_q;
`endif
         STOP:   tx = STOP_BIT;
         default: tx = STOP_BIT;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = done_q;

   // Datapath: capture the word on accept, shift one bit per data period,
   // accumulate parity per byte, and count bytes to find the end of the word.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         par_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (send) begin
                  shift_q  <= data;
                  bit_idx  <= '0;
                  byte_idx <= '0;
                  par_q    <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  bit_idx <= '0;
                  par_q   <= 1'b0;
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= shift_q >> 1;
                  par_q   <= par_q ^ shift_q[0];
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (byte_idx == LAST_BYTE)
                     done_q <= 1'b1;
                  else
                     byte_idx <= byte_idx + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Directed bench for mem_uart_tx with CLKS_PER_BIT=10 and a 16-bit word.
// Follows UART_PARITY_EN so the same bench serves both builds.
module tb_mem_uart_tx;

   localparam int CPB = 10;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME_CYC = 2 * FB * CPB;

   logic        clk;
   logic        reset;
   logic        send;
   logic [15:0] data;
   logic        tx;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [0:0] exp_q[$];

   mem_uart_tx #(
      .BIT_WIDTH (16),
      .CLK_FREQ  (100),
      .BAUD      (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .send  (send),
      .data  (data),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   // Clock: 10-unit period, rising edges at 5, 15, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected line bits for one whole word: LS byte first, LSB first.
   task automatic build_expected(input logic [15:0] w);
      logic [7:0] b;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         b = w[8*i +: 8];
         exp_q.push_back(1'b0);
         for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
`ifdef UART_PARITY_EN
         exp_q.push_back(^b);
`endif
         exp_q.push_back(1'b1);
      end
   endtask

   // Called at a falling edge; the next rising edge accepts send.
   task automatic start_send();
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
   endtask

   // Checks every cycle of a word, starting at the first cycle after accept,
   // and ends at the falling edge of the cycle in which busy drops.
   task automatic run_frame(input logic [15:0] w, input int send_k,
                            input int data_k, input logic [15:0] new_data,
                            input string tag);
      build_expected(w);
      for (int k = 0; k < FRAME_CYC; k++) begin
         check($sformatf("%s busy k=%0d", tag, k), busy, 1'b1);
         check($sformatf("%s done k=%0d", tag, k), done, 1'b0);
         check($sformatf("%s tx k=%0d", tag, k), tx, exp_q[k / CPB][0]);
         if (send_k >= 0) begin
            if (k == send_k) send = 1'b1;
            else if (k == send_k + 1) send = 1'b0;
         end
         if (k == data_k) data = new_data;
         @(negedge clk);
      end
      check({tag, " end busy"}, busy, 1'b0);
      check({tag, " end done"}, done, 1'b1);
      check({tag, " end tx"}, tx, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      send  = 1'b0;
      data  = 16'h0000;
      repeat (3) @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("idle busy", busy, 1'b0);

      // Basic transfer of 0xA55A.
      data = 16'hA55A;
      start_send();
      run_frame(16'hA55A, -1, -1, 16'h0, "basic");
      @(negedge clk);
      check("basic post done", done, 1'b0);
      check("basic post busy", busy, 1'b0);

      // A second send 50 cycles in must be ignored.
      data = 16'h1234;
      start_send();
      run_frame(16'h1234, 50, -1, 16'h0, "ignore");
      @(negedge clk);
      check("ignore single done", done, 1'b0);
      check("ignore no restart", busy, 1'b0);

      // Changing data mid-word must not alter the captured word.
      data = 16'h5AC3;
      start_send();
      run_frame(16'h5AC3, -1, 30, 16'hFFFF, "datachg");
      @(negedge clk);

      // Reset asserted in cycle 35 of a word.
      data = 16'hA55A;
      start_send();
      repeat (35) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset tx", tx, 1'b1);
      check("midreset busy", busy, 1'b0);
      check("midreset done", done, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("midreset idle", busy, 1'b0);
      data = 16'h3C96;
      start_send();
      run_frame(16'h3C96, -1, -1, 16'h0, "after_reset");
      @(negedge clk);

      // Reset wins over a simultaneous send.
      reset = 1'b1;
      send  = 1'b1;
      @(negedge clk);
      check("prio busy", busy, 1'b0);
      check("prio tx", tx, 1'b1);
      reset = 1'b0;
      send  = 1'b0;
      @(negedge clk);
      check("prio still idle", busy, 1'b0);

`ifdef UART_PARITY_EN
      // Odd-weight bytes 0x07 and 0x01 each carry parity 1.
      data = 16'h0107;
      start_send();
      run_frame(16'h0107, -1, -1, 16'h0, "parity");
      @(negedge clk);
`endif

      // send held high: two words separated by exactly one idle cycle.
      data = 16'h00FF;
      send = 1'b1;
      @(negedge clk);
      run_frame(16'h00FF, -1, -1, 16'h0, "cont1");
      @(negedge clk);
      run_frame(16'h00FF, -1, -1, 16'h0, "cont2");
      send = 1'b0;
      @(negedge clk);
      check("cont end busy", busy, 1'b0);
      check("cont end done", done, 1'b0);
      check("cont end tx", tx, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
